// File: rtl/dft_bin_streamer_pkg.sv
// Shared constants and state encoding for the DFT bin streamer.
// Also used by the upstream 8-point DFT stage.
package dft_bin_streamer_pkg;
  localparam int DW     = 32;
  localparam int N_BINS = 8;
  localparam int BIN_W  = 3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;
endpackage

// File: rtl/dft_bin_streamer_mag.sv
// L1 magnitude estimate |re|+|im| for one signed complex bin.
// Abs is taken in DW+1 bits so the most negative input is exact.
module bin_mag_l1 #(
  parameter int DW = 32
) (
  input  logic signed [DW-1:0] re,
  input  logic signed [DW-1:0] im,
  output logic        [DW:0]   mag
);
  logic [DW:0] re_ext;
  logic [DW:0] im_ext;
  logic [DW:0] re_abs;
  logic [DW:0] im_abs;

  always_comb begin
    re_ext = {re[DW-1], re};
    im_ext = {im[DW-1], im};
    re_abs = re[DW-1] ? (~re_ext + 1'b1) : re_ext;
    im_abs = im[DW-1] ? (~im_ext + 1'b1) : im_ext;
    mag    = re_abs + im_abs;
  end
endmodule

// File: rtl/dft_bin_streamer.sv
// Captures an 8-bin DFT frame and streams it out one bin per handshake,
// tracking the peak-magnitude bin of each frame.
module dft_bin_streamer
  import dft_bin_streamer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_valid,
  input  logic [N_BINS*DW-1:0] xr_flat,
  input  logic [N_BINS*DW-1:0] xi_flat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIN_W-1:0]     out_bin,
  output logic [DW-1:0]        out_re,
  output logic [DW-1:0]        out_im,
  output logic [DW:0]          out_mag,
  output logic                 out_last,
  output logic                 peak_valid,
  output logic [BIN_W-1:0]     peak_bin,
  output logic [DW:0]          peak_mag,
  output logic                 overrun
);
  state_e                      state_q, state_d;
  logic [BIN_W-1:0]            ptr_q, ptr_d;
  logic [N_BINS-1:0][DW-1:0]   re_q, re_d;
  logic [N_BINS-1:0][DW-1:0]   im_q, im_d;
  logic [DW:0]                 run_mag_q, run_mag_d;
  logic [BIN_W-1:0]            run_bin_q, run_bin_d;
  logic [DW:0]                 peak_mag_q, peak_mag_d;
  logic [BIN_W-1:0]            peak_bin_q, peak_bin_d;
  logic                        peak_valid_q, peak_valid_d;
  logic                        overrun_q, overrun_d;

  logic        hs;
  logic        last_hs;
  logic        win;
  logic        capture;
  logic [DW:0] mag;

  assign out_valid  = (state_q == ST_STREAM);
  assign out_bin    = ptr_q;
  assign out_re     = re_q[ptr_q];
  assign out_im     = im_q[ptr_q];
  assign out_mag    = mag;
  assign out_last   = out_valid && (ptr_q == BIN_W'(N_BINS-1));
  assign peak_valid = peak_valid_q;
  assign peak_bin   = peak_bin_q;
  assign peak_mag   = peak_mag_q;
  assign overrun    = overrun_q;

  bin_mag_l1 #(.DW(DW)) u_mag (
    .re  (re_q[ptr_q]),
    .im  (im_q[ptr_q]),
    .mag (mag)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    re_d         = re_q;
    im_d         = im_q;
    run_mag_d    = run_mag_q;
    run_bin_d    = run_bin_q;
    peak_mag_d   = peak_mag_q;
    peak_bin_d   = peak_bin_q;
    peak_valid_d = 1'b0;
    overrun_d    = overrun_q;

    hs      = out_valid && out_ready;
    last_hs = hs && out_last;
    win     = mag > run_mag_q;
    capture = frame_valid && (!out_valid || last_hs);

    if (hs) begin
      ptr_d = ptr_q + 1'b1;
      if (win) begin
        run_mag_d = mag;
        run_bin_d = ptr_q;
      end
    end

    if (last_hs) begin
      state_d      = ST_IDLE;
      peak_valid_d = 1'b1;
      peak_mag_d   = win ? mag : run_mag_q;
      peak_bin_d   = win ? ptr_q : run_bin_q;
    end

    // A capture on the final handshake overrides the IDLE return.
    if (capture) begin
      state_d   = ST_STREAM;
      ptr_d     = '0;
      re_d      = xr_flat;
      im_d      = xi_flat;
      run_mag_d = '0;
      run_bin_d = '0;
    end

    if (frame_valid && !capture)
      overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      re_q         <= '0;
      im_q         <= '0;
      run_mag_q    <= '0;
      run_bin_q    <= '0;
      peak_mag_q   <= '0;
      peak_bin_q   <= '0;
      peak_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      re_q         <= re_d;
      im_q         <= im_d;
      run_mag_q    <= run_mag_d;
      run_bin_q    <= run_bin_d;
      peak_mag_q   <= peak_mag_d;
      peak_bin_q   <= peak_bin_d;
      peak_valid_q <= peak_valid_d;
      overrun_q    <= overrun_d;
    end
  end
endmodule

// File: tb/tb_dft_bin_streamer.sv
// Directed bench for dft_bin_streamer: frame table plus
// backpressure, back-to-back, overrun and reset sequences.
module tb_dft_bin_streamer;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         frame_valid;
  logic [255:0] xr_flat;
  logic [255:0] xi_flat;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_bin;
  logic [31:0]  out_re;
  logic [31:0]  out_im;
  logic [32:0]  out_mag;
  logic         out_last;
  logic         peak_valid;
  logic [2:0]   peak_bin;
  logic [32:0]  peak_mag;
  logic         overrun;

  always #5 clk = ~clk;

  dft_bin_streamer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_valid (frame_valid),
    .xr_flat     (xr_flat),
    .xi_flat     (xi_flat),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_bin     (out_bin),
    .out_re      (out_re),
    .out_im      (out_im),
    .out_mag     (out_mag),
    .out_last    (out_last),
    .peak_valid  (peak_valid),
    .peak_bin    (peak_bin),
    .peak_mag    (peak_mag),
    .overrun     (overrun)
  );

  typedef struct {
    logic [7:0][31:0] re;
    logic [7:0][31:0] im;
    logic [7:0][32:0] mag;
    logic [2:0]       pbin;
    logic [32:0]      pmag;
  } vec_t;

  vec_t vt [5];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  task automatic load(input int f);
    xr_flat     = vt[f].re;
    xi_flat     = vt[f].im;
    frame_valid = 1'b1;
  endtask

  task automatic beat(input int f, input int b, input string t);
    chk({t, " valid"}, 64'(out_valid), 64'(1));
    chk({t, " bin"},   64'(out_bin),   64'(b));
    chk({t, " re"},    64'(out_re),    64'(vt[f].re[b]));
    chk({t, " im"},    64'(out_im),    64'(vt[f].im[b]));
    chk({t, " mag"},   64'(out_mag),   64'(vt[f].mag[b]));
    chk({t, " last"},  64'(out_last),  64'(b == 7));
  endtask

  task automatic peak(input int f, input string t);
    chk({t, " peak_valid"}, 64'(peak_valid), 64'(1));
    chk({t, " peak_bin"},   64'(peak_bin),   64'(vt[f].pbin));
    chk({t, " peak_mag"},   64'(peak_mag),   64'(vt[f].pmag));
  endtask

  task automatic run(input int f, input string t);
    @(negedge clk);
    load(f);
    out_ready = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      beat(f, b, t);
      @(negedge clk);
    end
    peak(f, t);
    chk({t, " idle"}, 64'(out_valid), 64'(0));
    @(negedge clk);
    chk({t, " pulse_end"}, 64'(peak_valid), 64'(0));
  endtask

  initial begin
    logic [3:0] pat;
    int         nb;
    int         pulses;

    for (int f = 0; f < 5; f++) begin
      vt[f].re   = '0;
      vt[f].im   = '0;
      vt[f].mag  = '0;
      vt[f].pbin = '0;
      vt[f].pmag = '0;
    end
    vt[0].re[0]  = 32'd44;
    vt[0].re[4]  = 32'd36;
    vt[0].mag[0] = 33'd44;
    vt[0].mag[4] = 33'd36;
    vt[0].pmag   = 33'd44;
    vt[1].re[3]  = 32'h8000_0000;
    vt[1].im[3]  = 32'h8000_0000;
    vt[1].mag[3] = 33'h1_0000_0000;
    vt[1].pbin   = 3'd3;
    vt[1].pmag   = 33'h1_0000_0000;
    vt[3].re[1]  = 32'd5;
    vt[3].re[2]  = -32'sd3;
    vt[3].im[2]  = -32'sd2;
    vt[3].re[7]  = -32'sd1;
    vt[3].im[7]  = 32'd1;
    vt[3].mag[1] = 33'd5;
    vt[3].mag[2] = 33'd5;
    vt[3].mag[7] = 33'd2;
    vt[3].pbin   = 3'd1;
    vt[3].pmag   = 33'd5;
    for (int b = 0; b < 8; b++) begin
      vt[4].re[b]  = (b % 2 == 0) ? 32'(b + 1) : -32'(b + 1);
      vt[4].mag[b] = 33'(b + 1);
    end
    vt[4].im[7]  = 32'd100;
    vt[4].mag[7] = 33'd108;
    vt[4].pbin   = 3'd7;
    vt[4].pmag   = 33'd108;

    rst_n       = 1'b0;
    frame_valid = 1'b0;
    out_ready   = 1'b0;
    xr_flat     = '0;
    xi_flat     = '0;
    repeat (2) @(negedge clk);
    chk("rst valid",    64'(out_valid),  64'(0));
    chk("rst bin",      64'(out_bin),    64'(0));
    chk("rst mag",      64'(out_mag),    64'(0));
    chk("rst peak_v",   64'(peak_valid), 64'(0));
    chk("rst peak_mag", 64'(peak_mag),   64'(0));
    chk("rst overrun",  64'(overrun),    64'(0));
    rst_n = 1'b1;

    for (int f = 0; f < 5; f++)
      run(f, $sformatf("tbl%0d", f));

    // backpressure: ready pattern 1,0,0,1 repeating
    pat = 4'b1001;
    @(negedge clk);
    load(4);
    out_ready = 1'b0;
    @(negedge clk);
    frame_valid = 1'b0;
    nb = 0;
    for (int cyc = 0; cyc < 60 && nb < 8; cyc++) begin
      beat(4, nb, "bp");
      out_ready = pat[cyc % 4];
      if (out_ready) nb++;
      @(negedge clk);
    end
    chk("bp beats", 64'(nb), 64'(8));
    peak(4, "bp");
    out_ready = 1'b1;

    // back-to-back capture on the bin-7 handshake
    pulses = 0;
    @(negedge clk);
    load(0);
    @(negedge clk);
    frame_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      beat(0, b, "b2b_a");
      if (b == 7) load(3);
      @(negedge clk);
      frame_valid = 1'b0;
      if (peak_valid) pulses++;
    end
    peak(0, "b2b_a");
    for (int b = 0; b < 8; b++) begin
      beat(3, b, "b2b_b");
      @(negedge clk);
      if (peak_valid) pulses++;
    end
    peak(3, "b2b_b");
    chk("b2b pulses",  64'(pulses),  64'(2));
    chk("b2b overrun", 64'(overrun), 64'(0));

    // overrun: extra frame arrives at bin 3
    @(negedge clk);
    load(4);
    @(negedge clk);
    frame_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      beat(4, b, "ovr");
      if (b == 3) load(0);
      @(negedge clk);
      frame_valid = 1'b0;
    end
    peak(4, "ovr");
    chk("ovr sticky", 64'(overrun),   64'(1));
    chk("ovr idle",   64'(out_valid), 64'(0));
    @(negedge clk);
    chk("ovr hold",   64'(overrun),   64'(1));

    // reset mid-stream at bin 5
    load(1);
    @(negedge clk);
    frame_valid = 1'b0;
    for (int b = 0; b < 6; b++) begin
      beat(1, b, "mid");
      if (b < 5) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("mr valid",    64'(out_valid),  64'(0));
    chk("mr bin",      64'(out_bin),    64'(0));
    chk("mr re",       64'(out_re),     64'(0));
    chk("mr im",       64'(out_im),     64'(0));
    chk("mr mag",      64'(out_mag),    64'(0));
    chk("mr last",     64'(out_last),   64'(0));
    chk("mr peak_v",   64'(peak_valid), 64'(0));
    chk("mr peak_bin", 64'(peak_bin),   64'(0));
    chk("mr peak_mag", 64'(peak_mag),   64'(0));
    chk("mr overrun",  64'(overrun),    64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("mr stale pulse", 64'(peak_valid), 64'(0));
      chk("mr stale valid", 64'(out_valid),  64'(0));
    end
    run(0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
